// File: rtl/neuron_mac.sv
// neuron_mac: fixed-point MAC neuron with runtime-writable weights/bias, round-half-up, saturation and activation.
// Define NEURON_SIGMOID_EN to compile in the 256-entry sigmoid ROM that makes ACTIVATION = 2 legal.

module neuron_mac #(
    parameter int INTG_WIDTH = 8,
    parameter int FRAC_WIDTH = 8,
    parameter int NUM_INPUTS = 16,
    parameter int LANES      = 4,
    parameter int ACTIVATION = 1,
    localparam int DATA_WIDTH = INTG_WIDTH + FRAC_WIDTH,
    localparam int ADDR_WIDTH = $clog2(NUM_INPUTS + 1)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] inputs [NUM_INPUTS],
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_addr,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    output logic signed [DATA_WIDTH-1:0] out,
    output logic                         out_valid,
    input  logic                         out_ready
);

    localparam int NUM_BEATS = NUM_INPUTS / LANES;
    localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam int IDX_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int PROD_W    = 2 * DATA_WIDTH;
    localparam int ACC_W     = 2 * DATA_WIDTH + $clog2(NUM_INPUTS + 1) + 1;

    localparam logic [BEAT_W-1:0]            LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
    localparam logic signed [DATA_WIDTH-1:0] W_ONE     = DATA_WIDTH'(1 << FRAC_WIDTH);
    localparam logic signed [ACC_W-1:0]      RND_HALF  = ACC_W'(1) << (FRAC_WIDTH - 1);
    localparam logic signed [ACC_W-1:0]      SAT_MAX   = {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]      SAT_MIN   = {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    if (NUM_INPUTS % LANES != 0) begin : g_chk_lanes
        $fatal(1, "neuron_mac: LANES must divide NUM_INPUTS");
    end
`ifdef NEURON_SIGMOID_EN
    if (ACTIVATION < 0 || ACTIVATION > 2) begin : g_chk_act
        $fatal(1, "neuron_mac: ACTIVATION must be 0, 1 or 2");
    end
    // ROM index takes bits FRAC_WIDTH+3..FRAC_WIDTH-4 of the offset value.
    if (INTG_WIDTH < 5 || FRAC_WIDTH < 4) begin : g_chk_sig_fmt
        $fatal(1, "neuron_mac: sigmoid needs INTG_WIDTH >= 5 and FRAC_WIDTH >= 4");
    end
`else
    if (ACTIVATION < 0 || ACTIVATION > 1) begin : g_chk_act
        $fatal(1, "neuron_mac: ACTIVATION must be 0 or 1 without NEURON_SIGMOID_EN");
    end
`endif

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ACTIVATE, S_HOLD} state_t;

    state_t                        state_q, state_d;
    logic signed [DATA_WIDTH-1:0]  in_q [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0]  in_d [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0]  w_q  [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0]  w_d  [NUM_INPUTS];
    logic signed [DATA_WIDTH-1:0]  bias_q, bias_d;
    logic signed [ACC_W-1:0]       sum_q, sum_d;
    logic [BEAT_W-1:0]             beat_q, beat_d;
    logic signed [DATA_WIDTH-1:0]  out_q, out_d;

    logic                          accept;
    logic [IDX_W-1:0]              lane_idx;
    logic signed [PROD_W-1:0]      lane_prod;
    logic signed [ACC_W-1:0]       beat_sum;
    logic signed [ACC_W-1:0]       rnd_sum;
    logic signed [ACC_W-1:0]       rnd_val;
    logic signed [DATA_WIDTH-1:0]  sat_val;
    logic signed [DATA_WIDTH-1:0]  act_val;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (accept) state_d = S_ACCUM;
            S_ACCUM:    if (beat_q == LAST_BEAT) state_d = S_ACTIVATE;
            S_ACTIVATE: state_d = S_HOLD;
            S_HOLD:     if (out_ready) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_HOLD);
    end

    assign accept = in_valid & in_ready;

    always_comb begin
        beat_sum  = '0;
        lane_idx  = '0;
        lane_prod = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_idx  = IDX_W'(int'(beat_q) * LANES + k);
            lane_prod = in_q[lane_idx] * w_q[lane_idx];
            beat_sum  = beat_sum + ACC_W'(lane_prod);
        end
    end

    always_comb begin
        rnd_sum = sum_q + RND_HALF;
        rnd_val = rnd_sum >>> FRAC_WIDTH;
        if (rnd_val > SAT_MAX) begin
            sat_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (rnd_val < SAT_MIN) begin
            sat_val = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            sat_val = rnd_val[DATA_WIDTH-1:0];
        end
    end

`ifdef NEURON_SIGMOID_EN
    localparam logic signed [DATA_WIDTH-1:0] SIG_HI  = DATA_WIDTH'((8 << FRAC_WIDTH) - 1);
    localparam logic signed [DATA_WIDTH-1:0] SIG_LO  = DATA_WIDTH'(-(8 << FRAC_WIDTH));
    localparam logic [DATA_WIDTH-1:0]        SIG_OFS = DATA_WIDTH'(8 << FRAC_WIDTH);

    // Entry i holds sigmoid sampled at the centre of its 1/16-wide bin over [-8, 8).
    function automatic logic [DATA_WIDTH-1:0] sig_entry(input int i);
        real x;
        real s;
        x = -8.0 + (real'(i) + 0.5) / 16.0;
        s = 1.0 / (1.0 + $exp(-x));
        return DATA_WIDTH'($rtoi(s * (2.0 ** FRAC_WIDTH) + 0.5));
    endfunction

    logic [DATA_WIDTH-1:0]        sig_rom [256];
    logic signed [DATA_WIDTH-1:0] sig_clamp;
    logic [DATA_WIDTH-1:0]        sig_off;
    logic [7:0]                   sig_idx;

    for (genvar g = 0; g < 256; g++) begin : g_sig_rom
        localparam logic [DATA_WIDTH-1:0] ENTRY = sig_entry(g);
        assign sig_rom[g] = ENTRY;
    end

    always_comb begin
        if (sat_val > SIG_HI) begin
            sig_clamp = SIG_HI;
        end else if (sat_val < SIG_LO) begin
            sig_clamp = SIG_LO;
        end else begin
            sig_clamp = sat_val;
        end
        sig_off = sig_clamp + SIG_OFS;
        sig_idx = sig_off[FRAC_WIDTH+3 -: 8];
    end
`endif

    always_comb begin
        act_val = sat_val;
        if (ACTIVATION == 1 && sat_val[DATA_WIDTH-1]) begin
            act_val = '0;
        end
`ifdef NEURON_SIGMOID_EN
        if (ACTIVATION == 2) begin
            act_val = sig_rom[sig_idx];
        end
`endif
    end

    // Weight/bias writes only land in IDLE when no vector is being taken.
    always_comb begin
        in_d   = in_q;
        w_d    = w_q;
        bias_d = bias_q;
        sum_d  = sum_q;
        beat_d = beat_q;
        out_d  = out_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    in_d   = inputs;
                    sum_d  = ACC_W'(bias_q) <<< FRAC_WIDTH;
                    beat_d = '0;
                end else if (wr_en) begin
                    if (wr_addr < ADDR_WIDTH'(NUM_INPUTS)) begin
                        w_d[wr_addr[IDX_W-1:0]] = wr_data;
                    end else if (wr_addr == ADDR_WIDTH'(NUM_INPUTS)) begin
                        bias_d = wr_data;
                    end
                end
            end
            S_ACCUM: begin
                sum_d  = sum_q + beat_sum;
                beat_d = beat_q + 1'b1;
            end
            S_ACTIVATE: out_d = act_val;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                in_q[i] <= '0;
                w_q[i]  <= W_ONE;
            end
            bias_q <= '0;
            sum_q  <= '0;
            beat_q <= '0;
            out_q  <= '0;
        end else begin
            in_q   <= in_d;
            w_q    <= w_d;
            bias_q <= bias_d;
            sum_q  <= sum_d;
            beat_q <= beat_d;
            out_q  <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: a ReLU and an identity instance share stimulus; a negedge monitor pops expectations.

module tb_neuron_mac;

    localparam int DW = 16;
    localparam int N  = 16;

    typedef logic signed [DW-1:0] vec_t [N];

    logic                 clock = 1'b0;
    logic                 reset_n;
    logic                 in_valid;
    logic                 wr_en;
    logic [4:0]           wr_addr;
    logic signed [DW-1:0] wr_data;
    logic                 out_ready;
    vec_t                 in_vec;

    logic                 in_ready_r, in_ready_i;
    logic                 out_valid_r, out_valid_i;
    logic signed [DW-1:0] out_r, out_i;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0]        q_relu [$];
    logic [DW-1:0]        q_id   [$];
    logic signed [DW-1:0] w_m    [N];
    logic signed [DW-1:0] bias_m;

    always #5 clock = ~clock;

    neuron_mac #(.ACTIVATION(1)) dut_relu (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_r),
        .inputs(in_vec), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out(out_r), .out_valid(out_valid_r), .out_ready(out_ready)
    );

    neuron_mac #(.ACTIVATION(0)) dut_id (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_i),
        .inputs(in_vec), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .out(out_i), .out_valid(out_valid_i), .out_ready(out_ready)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%04h, want 0x%04h", name, act, exp);
        end
    endtask

    // Reference: real-valued dot product in Q8.8 integers, round half up, clamp, optional ReLU.
    function automatic logic [DW-1:0] model(input vec_t v, input bit relu);
        longint acc;
        longint r;
        acc = longint'(bias_m) * 256;
        for (int i = 0; i < N; i++) acc += longint'(v[i]) * longint'(w_m[i]);
        r = (acc + 128) >>> 8;
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
        if (relu && r < 0) r = 0;
        return DW'(r);
    endfunction

    function automatic logic [DW-1:0] rs();
        return DW'(int'($urandom_range(0, 1023)) - 512);
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) w_m[i] = 16'h0100;
        bias_m = '0;
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] data);
        wr_en   = 1'b1;
        wr_addr = 5'(addr);
        wr_data = data;
        step();
        wr_en = 1'b0;
        if (addr < N) w_m[addr] = data;
        else if (addr == N) bias_m = data;
    endtask

    // wmode 1: write w[5] alongside the accept; wmode 2: write w[3] during ACCUM. Both must be dropped.
    task automatic send_vec(input vec_t v, input int hold, input int wmode);
        int            n;
        int            lat;
        bit            busy_ok;
        bit            stable;
        logic [DW-1:0] held_r;
        logic [DW-1:0] held_i;
        n = 0;
        while (!in_ready_r && n < 50) begin
            step();
            n++;
        end
        check("in_ready before send", {15'd0, in_ready_r}, 16'd1);
        in_vec   = v;
        in_valid = 1'b1;
        if (wmode == 1) begin
            wr_en   = 1'b1;
            wr_addr = 5'd5;
            wr_data = 16'h4321;
        end
        q_relu.push_back(model(v, 1'b1));
        q_id.push_back(model(v, 1'b0));
        step();
        in_valid = 1'b0;
        wr_en    = 1'b0;
        lat      = 0;
        busy_ok  = 1'b1;
        while (!out_valid_r && lat < 20) begin
            if (in_ready_r || in_ready_i) busy_ok = 1'b0;
            if (wmode == 2 && lat == 1) begin
                wr_en   = 1'b1;
                wr_addr = 5'd3;
                wr_data = 16'h1234;
            end else begin
                wr_en = 1'b0;
            end
            step();
            lat++;
        end
        wr_en = 1'b0;
        check("latency", DW'(lat), 16'd5);
        check("in_ready low while busy", {15'd0, busy_ok}, 16'd1);
        held_r = out_r;
        held_i = out_i;
        stable = 1'b1;
        for (int c = 0; c < hold; c++) begin
            step();
            if (out_r !== held_r || out_i !== held_i || !out_valid_r || in_ready_r) stable = 1'b0;
        end
        if (hold > 0) check("hold stable under backpressure", {15'd0, stable}, 16'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("in_ready after consume", {15'd0, in_ready_r}, 16'd1);
        check("out kept after consume", out_r, held_r);
    endtask

    always @(negedge clock) begin
        if (reset_n && out_ready) begin
            if (out_valid_r) begin
                if (q_relu.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL relu unexpected output: got 0x%04h, want none", out_r);
                end else begin
                    check("relu out", out_r, q_relu.pop_front());
                end
            end
            if (out_valid_i) begin
                if (q_id.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL identity unexpected output: got 0x%04h, want none", out_i);
                end else begin
                    check("identity out", out_i, q_id.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        out_ready = 1'b0;
        for (int i = 0; i < N; i++) in_vec[i] = '0;
        model_reset();
        repeat (3) step();
        reset_n = 1'b1;
        step();

        check("reset in_ready", {15'd0, in_ready_r}, 16'd1);
        check("reset out_valid", {15'd0, out_valid_r}, 16'd0);
        check("reset out", out_r, 16'h0000);

        for (int i = 0; i < N; i++) v[i] = 16'h0100;
        send_vec(v, 0, 0);

        wr(N, 16'h0080);
        for (int i = 0; i < N; i++) v[i] = 16'hFF00;
        send_vec(v, 0, 0);

        for (int i = 0; i < N; i++) wr(i, 16'h7FFF);
        for (int i = 0; i < N; i++) v[i] = 16'h7FFF;
        send_vec(v, 0, 0);
        for (int i = 0; i < N; i++) v[i] = 16'h8000;
        send_vec(v, 0, 0);

        wr(N, 16'h0000);
        wr(0, 16'h0080);
        for (int i = 0; i < N; i++) v[i] = '0;
        v[0] = 16'h0001;
        send_vec(v, 0, 0);
        v[0] = 16'hFFFF;
        send_vec(v, 0, 0);

        for (int i = 0; i <= N; i++) wr(i, rs());
        wr(N + 1, 16'h7777);
        for (int i = 0; i < N; i++) v[i] = rs();
        send_vec(v, 10, 2);
        for (int i = 0; i < N; i++) v[i] = rs();
        send_vec(v, 3, 1);

        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 1) == 1) wr(int'($urandom_range(0, N)), rs());
            for (int i = 0; i < N; i++) v[i] = rs();
            send_vec(v, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
        end

        wr(N, 16'h0180);
        for (int i = 0; i < N; i++) v[i] = rs();
        in_vec   = v;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        model_reset();
        step();
        check("post-reset out_valid", {15'd0, out_valid_r}, 16'd0);
        check("post-reset in_ready", {15'd0, in_ready_r}, 16'd1);
        check("post-reset out", out_r, 16'h0000);
        check("post-reset identity out", out_i, 16'h0000);
        for (int i = 0; i < N; i++) v[i] = 16'h0100;
        send_vec(v, 0, 0);
        for (int i = 0; i < N; i++) v[i] = rs();
        send_vec(v, 1, 0);

        repeat (3) step();
        check("scoreboard drained", DW'(q_relu.size() + q_id.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
